// File: rtl/ft_pkg.sv
// Shared definitions for the checkpoint/recovery controller: FSM state
// encoding, default geometry and the restore watchdog limit.
package ft_pkg;

  localparam int unsigned NUM_REGS_DEF   = 32;
  localparam int unsigned PC_ADDR_DEF    = 32;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned IDX_W          = 6;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_REGS,
    SAVE_PC,
    REST_REQ,
    REST_WAIT,
    DONE
  } ft_state_e;

endpackage

// File: rtl/ft_watchdog.sv
// Restore watchdog: cleared while a read is being requested, counts the
// cycles spent waiting for read data and flags expiry once LIMIT cycles
// have elapsed without data. Only instantiated when the optional restore
// timeout (FT_RECOVERY_TIMEOUT_EN) is built in.
module ft_watchdog
  import ft_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned    CW      = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on load, otherwise saturating increment while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = count_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Checkpoint / recovery controller. A save copies the core register file
// and PC into checkpoint memory; a restore reads them back over a
// req/gnt/rvalid port and writes them into the core.
// Optional feature: define FT_RECOVERY_TIMEOUT_EN to abort a restore with
// an err_o pulse when read data does not arrive within TIMEOUT_CYCLES.
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned PC_ADDR  = PC_ADDR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ckpt_req_i,
  input  logic        recov_req_i,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  input  logic [31:0] pc_i,
  output logic        we_rf_o,
  output logic [4:0]  addr_rf_o,
  output logic [31:0] data_rf_o,
  output logic        load_pc_o,
  output logic [31:0] pc_o,
  output logic        req_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  output logic [31:0] addr_o,
  input  logic [31:0] rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        pc_rst_valid_o,
  output logic [31:0] pc_rst_o,
  output logic        halt_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(NUM_REGS);
  localparam logic [29:0]      PC_WORD  = 30'(PC_ADDR);

  ft_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [29:0]      idx_word;

  // idx runs one past the last register to select the PC slot.
  assign idx_word = (idx_q < PC_IDX) ? {{(30-IDX_W){1'b0}}, idx_q} : PC_WORD;

`ifdef FT_RECOVERY_TIMEOUT_EN
  logic wd_load;
  logic wd_count;
  logic wd_expire;

  assign wd_load  = (state_q == REST_REQ);
  assign wd_count = (state_q == REST_WAIT) && !rvalid_i;

  ft_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (wd_load),
    .count_i  (wd_count),
    .expire_o (wd_expire)
  );
`endif

  // State and index registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (recov_req_i) begin
          state_d = REST_REQ;
          idx_d   = '0;
        end else if (ckpt_req_i) begin
          state_d = SAVE_REGS;
          idx_d   = '0;
        end
      end
      SAVE_REGS: begin
        if (idx_q == LAST_IDX) begin
          state_d = SAVE_PC;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SAVE_PC: begin
        state_d = DONE;
      end
      REST_REQ: begin
        if (gnt_i) begin
          state_d = REST_WAIT;
        end
      end
      REST_WAIT: begin
        if (rvalid_i) begin
          if (idx_q == PC_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REST_REQ;
          end
        end
`ifdef FT_RECOVERY_TIMEOUT_EN
        else if (wd_expire) begin
          state_d = IDLE;
          idx_d   = '0;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode: every strobe and data bus is zero outside its own state.
  always_comb begin
    rf_raddr_o     = '0;
    we_rf_o        = 1'b0;
    addr_rf_o      = '0;
    data_rf_o      = '0;
    load_pc_o      = 1'b0;
    pc_o           = '0;
    req_o          = 1'b0;
    addr_o         = '0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    pc_rst_valid_o = 1'b0;
    pc_rst_o       = '0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    halt_o         = (state_q != IDLE);
    case (state_q)
      SAVE_REGS: begin
        rf_raddr_o = idx_q[4:0];
        we_rf_o    = 1'b1;
        addr_rf_o  = idx_q[4:0];
        data_rf_o  = rf_rdata_i;
      end
      SAVE_PC: begin
        load_pc_o = 1'b1;
        pc_o      = pc_i;
      end
      REST_REQ: begin
        req_o  = 1'b1;
        addr_o = {idx_word, 2'b00};
      end
      REST_WAIT: begin
        // Address held after the grant: memory samples it every cycle.
        addr_o = {idx_word, 2'b00};
        if (rvalid_i) begin
          if (idx_q < PC_IDX) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = idx_q[4:0];
            rf_wdata_o = rdata_i;
          end else begin
            pc_rst_valid_o = 1'b1;
            pc_rst_o       = rdata_i;
          end
        end
`ifdef FT_RECOVERY_TIMEOUT_EN
        else if (wd_expire) begin
          err_o = 1'b1;
        end
`endif
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Structural invariants: idx stays within the PC slot, strobes are exclusive.
  a_idx_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    idx_q <= PC_IDX);
  a_strobe_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({we_rf_o, load_pc_o, req_o, rf_we_o, pc_rst_valid_o, done_o, err_o}));

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Scoreboard bench for ft_recovery_ctrl: stimulus pushes expected events,
// a monitor pops and compares them as the DUT strobes outputs.
module tb_ft_recovery_ctrl;

  localparam int unsigned NR  = 32;
  localparam int unsigned PCA = 32;
  localparam int unsigned TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ckpt_req_i = 1'b0;
  logic        recov_req_i = 1'b0;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic [31:0] pc_i = '0;
  logic        we_rf_o;
  logic [4:0]  addr_rf_o;
  logic [31:0] data_rf_o;
  logic        load_pc_o;
  logic [31:0] pc_o;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] addr_o;
  logic [31:0] rdata_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        pc_rst_valid_o;
  logic [31:0] pc_rst_o;
  logic        halt_o;
  logic        done_o;
  logic        err_o;

  ft_recovery_ctrl #(
    .NUM_REGS (NR),
    .PC_ADDR  (PCA)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ckpt_req_i     (ckpt_req_i),
    .recov_req_i    (recov_req_i),
    .rf_raddr_o     (rf_raddr_o),
    .rf_rdata_i     (rf_rdata_i),
    .pc_i           (pc_i),
    .we_rf_o        (we_rf_o),
    .addr_rf_o      (addr_rf_o),
    .data_rf_o      (data_rf_o),
    .load_pc_o      (load_pc_o),
    .pc_o           (pc_o),
    .req_o          (req_o),
    .gnt_i          (gnt_i),
    .rvalid_i       (rvalid_i),
    .addr_o         (addr_o),
    .rdata_i        (rdata_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .pc_rst_valid_o (pc_rst_valid_o),
    .pc_rst_o       (pc_rst_o),
    .halt_o         (halt_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {EV_SW, EV_SP, EV_RW, EV_RP, EV_DN, EV_ER} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned idx;
    logic [31:0] data;
  } ev_t;
  typedef struct {
    logic [31:0] addr;
    int unsigned len;
  } rq_t;

  ev_t exp_q[$];
  rq_t req_q[$];

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned t0  = 0;

  logic [31:0] rf  [NR];
  logic [31:0] mem [PCA+1];
  int unsigned stall_tab [PCA+1];
  bit mute = 1'b0;

  assign rf_rdata_i = rf[rf_raddr_o];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input ev_kind_e k, input int unsigned i, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    e.data = d;
    return e;
  endfunction

  function automatic logic outs_nz();
    return |{rf_raddr_o, we_rf_o, addr_rf_o, data_rf_o, load_pc_o, pc_o, req_o, addr_o,
             rf_we_o, rf_waddr_o, rf_wdata_o, pc_rst_valid_o, pc_rst_o, halt_o, done_o, err_o};
  endfunction

  task automatic take(input ev_kind_e k, input int unsigned i, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d data=%h want none", int'(k), i, d);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", 32'(int'(k)), 32'(int'(e.kind)));
      chk("ev_idx", 32'(i), 32'(e.idx));
      chk("ev_data", d, e.data);
    end
  endtask

  // Memory responder: grant after the configured stall, data one cycle after grant.
  initial begin : responder
    bit          hs;
    bit          pend;
    int unsigned w;
    int unsigned w2;
    int unsigned stall;
    hs = 0; pend = 0; w = 0; w2 = 0; stall = 0;
    forever begin
      @(negedge clk_i);
      hs = rst_ni && req_o && gnt_i;
      w  = int'(addr_o[31:2]);
      @(posedge clk_i);
      #1;
      rvalid_i = 1'b0;
      if (hs) begin
        pend = 0;
        if (!mute && w <= PCA) begin
          rvalid_i = 1'b1;
          rdata_i  = mem[w];
        end
      end
      if (req_o) begin
        if (!pend) begin
          pend  = 1;
          w2    = int'(addr_o[31:2]);
          stall = (w2 <= PCA) ? stall_tab[w2] : 0;
        end
        gnt_i = (stall == 0);
        if (stall != 0) stall--;
      end else begin
        pend  = 0;
        gnt_i = 1'b0;
      end
    end
  end

  // Monitor: pops expected events on every strobe and checks request timing.
  initial begin : monitor
    int unsigned run;
    logic [31:0] run_addr;
    bit          waiting;
    rq_t         r;
    run = 0; run_addr = '0; waiting = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        run = 0;
        waiting = 0;
        continue;
      end
      if (we_rf_o)        take(EV_SW, 32'(addr_rf_o), data_rf_o);
      if (load_pc_o)      take(EV_SP, 0, pc_o);
      if (rf_we_o)        take(EV_RW, 32'(rf_waddr_o), rf_wdata_o);
      if (pc_rst_valid_o) take(EV_RP, 0, pc_rst_o);
      if (done_o)         take(EV_DN, 0, 32'(cyc - t0));
      if (err_o)          take(EV_ER, 0, 32'(cyc - t0));
      if (req_o) begin
        if (run == 0) run_addr = addr_o;
        else chk("req_addr_hold", addr_o, run_addr);
        run++;
      end else if (run > 0) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got addr=%h len=%0d want none", run_addr, run);
        end else begin
          r = req_q.pop_front();
          chk("req_addr", run_addr, r.addr);
          chk("req_len", 32'(run), 32'(r.len));
        end
        run = 0;
        waiting = 1;
      end
      if (!halt_o) waiting = 0;
      if (waiting) begin
        chk("wait_addr_hold", addr_o, run_addr);
        if (rvalid_i) waiting = 0;
      end
    end
  end

  task automatic push_save();
    for (int i = 0; i < int'(NR); i++) exp_q.push_back(mk(EV_SW, i, rf[i]));
    exp_q.push_back(mk(EV_SP, 0, pc_i));
    exp_q.push_back(mk(EV_DN, 0, 32'(NR + 2)));
  endtask

  task automatic push_restore();
    int unsigned t;
    int unsigned word;
    rq_t r;
    t = 0;
    for (int w = 0; w <= int'(NR); w++) begin
      word   = (w < int'(NR)) ? w : PCA;
      r.addr = 32'(word * 4);
      r.len  = stall_tab[word] + 1;
      req_q.push_back(r);
      t += stall_tab[word] + 2;
      if (w < int'(NR)) exp_q.push_back(mk(EV_RW, w, mem[word]));
      else              exp_q.push_back(mk(EV_RP, 0, mem[word]));
    end
    exp_q.push_back(mk(EV_DN, 0, 32'(t + 1)));
  endtask

  task automatic start(input bit ck, input bit rc);
    @(posedge clk_i);
    #1;
    ckpt_req_i  = ck;
    recov_req_i = rc;
    @(posedge clk_i);
    #1;
    t0 = cyc - 1;
    ckpt_req_i  = 1'b0;
    recov_req_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit spur);
    bit ok;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i);
      #1;
      if (spur && halt_o && !done_o && !err_o) begin
        ckpt_req_i  = ($urandom_range(0, 3) == 0);
        recov_req_i = ($urandom_range(0, 3) == 0);
      end else begin
        ckpt_req_i  = 1'b0;
        recov_req_i = 1'b0;
      end
      if (!halt_o && exp_q.size() == 0 && req_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    ckpt_req_i  = 1'b0;
    recov_req_i = 1'b0;
    chk({name, "_complete"}, 32'(ok), 32'd1);
    if (!ok) begin
      exp_q.delete();
      req_q.delete();
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(NR); i++) rf[i] = $urandom;
    for (int i = 0; i <= int'(PCA); i++) begin
      mem[i]       = $urandom;
      stall_tab[i] = $urandom_range(0, 2);
    end
    pc_i = $urandom;
  endtask

  initial begin : timeout_guard
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    bit found;
    for (int i = 0; i <= int'(PCA); i++) begin
      mem[i] = '0;
      stall_tab[i] = 0;
    end
    for (int i = 0; i < int'(NR); i++) rf[i] = '0;

    // Reset state.
    #12;
    chk("reset_outs", 32'(outs_nz()), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("idle_outs", 32'(outs_nz()), 32'd0);

    // Directed save.
    for (int i = 0; i < int'(NR); i++) rf[i] = 32'hA000_0000 + 32'(i);
    pc_i = 32'h0000_0100;
    push_save();
    start(1'b1, 1'b0);
    wait_idle("save_directed", 1'b0);

    // Directed restore, grant tied to request.
    for (int i = 0; i < int'(NR); i++) mem[i] = 32'hB0 + 32'(i);
    mem[PCA] = 32'h200;
    for (int i = 0; i <= int'(PCA); i++) stall_tab[i] = 0;
    push_restore();
    start(1'b0, 1'b1);
    wait_idle("restore_directed", 1'b0);

    // Both requests at once: restore must win.
    fill_random();
    for (int i = 0; i <= int'(PCA); i++) stall_tab[i] = 0;
    push_restore();
    start(1'b1, 1'b1);
    wait_idle("both_req", 1'b0);

    // Grant delayed by three cycles on word 5.
    fill_random();
    for (int i = 0; i <= int'(PCA); i++) stall_tab[i] = 0;
    stall_tab[5] = 3;
    push_restore();
    start(1'b0, 1'b1);
    wait_idle("gnt_stall", 1'b0);

    // Reset in the middle of a save, then a fresh save from idx 0.
    fill_random();
    push_save();
    start(1'b1, 1'b0);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (we_rf_o && addr_rf_o == 5'd10) begin
        found = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    chk("reached_idx10", 32'(found), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrun_reset_outs", 32'(outs_nz()), 32'd0);
    exp_q.delete();
    req_q.delete();
    @(posedge clk_i);
    #1;
    chk("held_reset_outs", 32'(outs_nz()), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("no_resume_halt", 32'(halt_o), 32'd0);
    for (int i = 0; i < int'(NR); i++) rf[i] = 32'hA000_0000 + 32'(i);
    pc_i = 32'h0000_0100;
    push_save();
    start(1'b1, 1'b0);
    wait_idle("save_after_reset", 1'b0);

    // Random operations with spurious requests while busy.
    for (int it = 0; it < 8; it++) begin
      fill_random();
      if ($urandom_range(0, 1) == 0) begin
        push_save();
        start(1'b1, 1'b0);
      end else begin
        push_restore();
        start($urandom_range(0, 1) == 1, 1'b1);
      end
      wait_idle("random_op", 1'b1);
    end

`ifdef FT_RECOVERY_TIMEOUT_EN
    // Read data never returns: abort with err_o, no done_o.
    begin
      rq_t r;
      for (int i = 0; i <= int'(PCA); i++) stall_tab[i] = 0;
      mute = 1'b1;
      r.addr = '0;
      r.len  = 1;
      req_q.push_back(r);
      exp_q.push_back(mk(EV_ER, 0, 32'(TMO + 2)));
      start(1'b0, 1'b1);
      wait_idle("restore_timeout", 1'b0);
      mute = 1'b0;
      chk("timeout_halt_drop", 32'(halt_o), 32'd0);
    end
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
